// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flush, memory-wait freeze and timeout trap.
// Optional stall performance counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_stall_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        Clock,
   input  logic        ResetN,
   input  logic [4:0]  IDrs,
   input  logic [4:0]  IDrt,
   input  logic        IDUsesRt,
   input  logic        EXMemToReg,
   input  logic        EXRegWrite,
   input  logic [4:0]  EXrt,
   input  logic        EXBranchTaken,
   input  logic        MemReq,
   input  logic        MemReady,
   output logic        PCEnable,
   output logic        IFIDDevEnable,
   output logic        IDEXDevEnable,
   output logic        EXMEMDevEnable,
   output logic        IDEXEnable,
   output logic        IFIDFlush,
   output logic        MemError,
   output logic [15:0] StallCycles
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_e;

   localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

   state_e     state_q, state_d;
   logic [7:0] wcnt_q, wcnt_d;
   logic       mem_error_q, mem_error_d;
   logic       freeze;
   logic       load_use;

   always_comb begin
      freeze = 1'b0;
      unique case (state_q)
         RUN:      freeze = MemReq & ~MemReady;
         MEM_WAIT: freeze = ~MemReady;
         FAULT:    freeze = 1'b1;
         default:  freeze = 1'b1;
      endcase
   end

   assign load_use = EXMemToReg & EXRegWrite & (EXrt != 5'd0) &
                     ((EXrt == IDrs) | (IDUsesRt & (EXrt == IDrt)));

   // State register
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q     <= RUN;
         wcnt_q      <= 8'd0;
         mem_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         mem_error_q <= mem_error_d;
      end
   end

   // Next-state logic
   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      mem_error_d = mem_error_q;
      unique case (state_q)
         RUN: begin
            if (MemReq && !MemReady) begin
               state_d = MEM_WAIT;
               wcnt_d  = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (MemReady) begin
               state_d = RUN;
               wcnt_d  = 8'd0;
            end else if (wcnt_q == TIMEOUT_C) begin
               state_d     = FAULT;
               mem_error_d = 1'b1;
            end else begin
               wcnt_d = wcnt_q + 8'd1;
            end
         end
         FAULT:   state_d = FAULT;
         default: state_d = FAULT;
      endcase
   end

   // Outputs are forced low while reset is asserted, independent of the clock.
   always_comb begin
      PCEnable       = 1'b0;
      IFIDDevEnable  = 1'b0;
      IDEXDevEnable  = 1'b0;
      EXMEMDevEnable = 1'b0;
      IDEXEnable     = 1'b0;
      IFIDFlush      = 1'b0;
      if (ResetN) begin
         if (freeze) begin
            IDEXEnable = 1'b1;
         end else if (EXBranchTaken) begin
            PCEnable       = 1'b1;
            IFIDDevEnable  = 1'b1;
            IDEXDevEnable  = 1'b1;
            EXMEMDevEnable = 1'b1;
            IFIDFlush      = 1'b1;
         end else if (load_use) begin
            IDEXDevEnable  = 1'b1;
            EXMEMDevEnable = 1'b1;
         end else begin
            PCEnable       = 1'b1;
            IFIDDevEnable  = 1'b1;
            IDEXDevEnable  = 1'b1;
            EXMEMDevEnable = 1'b1;
            IDEXEnable     = 1'b1;
         end
      end
   end

   assign MemError = mem_error_q;

`ifdef HAZARD_STALL_CNT_EN
   logic [15:0] stall_cycles_q, stall_cycles_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (!PCEnable && stall_cycles_q != 16'hFFFF)
         stall_cycles_d = stall_cycles_q + 16'd1;
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) stall_cycles_q <= 16'h0000;
      else         stall_cycles_q <= stall_cycles_d;
   end

   assign StallCycles = stall_cycles_q;
`else
   assign StallCycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed test-plan steps followed by randomized cycles
// compared against a cycle-level behavioural model of the control rules.
module tb_hazard_stall_ctrl;

   localparam int TO = 4;

   logic        Clock;
   logic        ResetN;
   logic [4:0]  IDrs, IDrt, EXrt;
   logic        IDUsesRt, EXMemToReg, EXRegWrite, EXBranchTaken, MemReq, MemReady;
   logic        PCEnable, IFIDDevEnable, IDEXDevEnable, EXMEMDevEnable, IDEXEnable, IFIDFlush;
   logic        MemError;
   logic [15:0] StallCycles;

   int tests = 0;
   int fails = 0;

   // Model: cycles spent waiting on memory (0 = not waiting), fault flag, stall count
   int m_wait  = 0;
   bit m_fault = 1'b0;
   int m_stall = 0;

   hazard_stall_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .Clock(Clock), .ResetN(ResetN),
      .IDrs(IDrs), .IDrt(IDrt), .IDUsesRt(IDUsesRt),
      .EXMemToReg(EXMemToReg), .EXRegWrite(EXRegWrite), .EXrt(EXrt),
      .EXBranchTaken(EXBranchTaken), .MemReq(MemReq), .MemReady(MemReady),
      .PCEnable(PCEnable), .IFIDDevEnable(IFIDDevEnable), .IDEXDevEnable(IDEXDevEnable),
      .EXMEMDevEnable(EXMEMDevEnable), .IDEXEnable(IDEXEnable), .IFIDFlush(IFIDFlush),
      .MemError(MemError), .StallCycles(StallCycles)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check mid-cycle against the model, then advance the model at the edge.
   task automatic step(input logic rst, input logic brk, input logic mreq, input logic mrdy,
                       input logic mtr, input logic rw, input logic [4:0] ert,
                       input logic [4:0] irs, input logic [4:0] irt, input logic uses,
                       input string tag);
      bit         frz, lu;
      logic [5:0] exp_ctrl;
      int         exp_stall;
      ResetN = rst; EXBranchTaken = brk; MemReq = mreq; MemReady = mrdy;
      EXMemToReg = mtr; EXRegWrite = rw; EXrt = ert; IDrs = irs; IDrt = irt; IDUsesRt = uses;
      if (!rst) begin
         m_wait = 0; m_fault = 1'b0; m_stall = 0;
      end
      #4;
      frz = m_fault || ((m_wait > 0) ? !mrdy : (mreq && !mrdy));
      lu  = mtr && rw && (ert != 0) && ((ert == irs) || (uses && ert == irt));
      // {PCEnable, IFIDDevEnable, IDEXDevEnable, EXMEMDevEnable, IDEXEnable, IFIDFlush}
      if (!rst)     exp_ctrl = 6'b000000;
      else if (frz) exp_ctrl = 6'b000010;
      else if (brk) exp_ctrl = 6'b111101;
      else if (lu)  exp_ctrl = 6'b001100;
      else          exp_ctrl = 6'b111110;
`ifdef HAZARD_STALL_CNT_EN
      exp_stall = m_stall;
`else
      exp_stall = 0;
`endif
      check({tag, "_ctrl"}, {10'd0, PCEnable, IFIDDevEnable, IDEXDevEnable, EXMEMDevEnable,
                             IDEXEnable, IFIDFlush}, {10'd0, exp_ctrl});
      check({tag, "_err"}, {15'd0, MemError}, {15'd0, m_fault});
      check({tag, "_stall"}, StallCycles, 16'(exp_stall));
      @(posedge Clock);
      if (rst) begin
         if (!exp_ctrl[5] && m_stall < 65535) m_stall++;
         if (frz) begin
            if (!m_fault) begin
               if (m_wait == 0)       m_wait = 1;
               else if (m_wait == TO) m_fault = 1'b1;
               else                   m_wait++;
            end
         end else begin
            m_wait = 0;
         end
      end
      #1;
   endtask

   initial begin
      // Reset and basic advance
      step(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "reset");
      step(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "reset2");
      step(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "advance");

      // Load-use via rs, then load has moved on
      step(1, 0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, "lu_rs");
      step(1, 0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd0, 0, "lu_clear");
      step(1, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 1, "lu_zero");
      step(1, 0, 0, 0, 1, 1, 5'd7, 5'd1, 5'd7, 1, "lu_rt");
      step(1, 0, 0, 0, 1, 1, 5'd7, 5'd1, 5'd7, 0, "lu_rt_unused");
      step(1, 0, 0, 0, 1, 0, 5'd5, 5'd5, 5'd5, 1, "lu_norw");

      // Branch beats load-use
      step(1, 1, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, "br_lu");

      // Memory wait: 3 freeze cycles then release
      step(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "mw1");
      step(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "mw2");
      step(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "mw3");
      step(1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, "mw_rel");
      step(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "mw_after");

      // Ready in the first request cycle: no freeze
      step(1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, "mw_fast");

      // Branch held through a 2-cycle wait: flush only on release
      step(1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "brw1");
      step(1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "brw2");
      step(1, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, "brw_rel");

      // Load-use seen during a freeze re-evaluates on release
      step(1, 0, 1, 0, 1, 1, 5'd3, 5'd3, 5'd0, 0, "luw1");
      step(1, 0, 1, 1, 1, 1, 5'd3, 5'd3, 5'd0, 0, "luw_rel");

      // Reset mid-wait
      step(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "rw1");
      step(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "rw2");
      step(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "rw_rst");
      step(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "rw_after");

      // Timeout: 1 RUN freeze + TO wait cycles, then FAULT sticks even with MemReady
      for (int i = 0; i < TO + 4; i++)
         step(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, $sformatf("to%0d", i));
      step(1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, "to_ready");
      step(1, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, "to_branch");
      step(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, "to_rst");
      step(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "to_after");

      // Randomized cycles with small register fields so hazards occur often
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline control block that drives the stage-holding registers of the 5-stage MIPS pipeline: it generates the per-stage DevEnable and bubble (Enable) controls the ID/EX, IF/ID, EX/MEM holders and PC consume. It detects load-use hazards, flushes on branches taken in EX, freezes the pipeline for multi-cycle data-memory accesses, and traps a memory timeout. It sits beside the decode stage and reads fields already latched in the ID/EX holder.

## Interface
Parameters:
- MEM_TIMEOUT, 16: max consecutive MEM_WAIT cycles before fault; legal range 1..255.

Ports:
- Clock  in  1  single clock, rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- IDrs, IDrt  in  5 each  source fields of instruction in ID.
- IDUsesRt  in  1  ID instruction reads rt as a source.
- EXMemToReg, EXRegWrite  in  1 each  control bits of instruction in EX (from ID/EX holder).
- EXrt  in  5  rt (load destination) of instruction in EX.
- EXBranchTaken  in  1  branch in EX resolved taken.
- MemReq, MemReady  in  1 each  data-memory access active in MEM / completes this cycle.
- PCEnable  out  1  PC update enable.
- IFIDDevEnable, IDEXDevEnable, EXMEMDevEnable  out  1 each  holder load enables.
- IDEXEnable  out  1  0 = insert bubble into ID/EX.
- IFIDFlush  out  1  clear IF/ID instruction.
- MemError  out  1  sticky timeout fault.
- StallCycles  out  16  stall performance counter.

## Operation
- FSM states: RUN, MEM_WAIT, FAULT. 8-bit wait counter WCnt.
- Freeze (PCEnable, IFIDDevEnable, IDEXDevEnable, EXMEMDevEnable all 0; IDEXEnable 1; IFIDFlush 0) when: RUN with MemReq=1 & MemReady=0; MEM_WAIT with MemReady=0; FAULT always.
- Advance cycle (any non-freeze cycle), priority order:
  - EXBranchTaken=1: all enables 1, IFIDFlush=1, IDEXEnable=0; load-use ignored.
  - Load-use = EXMemToReg & EXRegWrite & EXrt!=0 & (EXrt==IDrs | (IDUsesRt & EXrt==IDrt)): PCEnable=0, IFIDDevEnable=0, IDEXDevEnable=1, IDEXEnable=0, EXMEMDevEnable=1, IFIDFlush=0.
  - Otherwise: all enables 1, IDEXEnable=1, IFIDFlush=0.
- Transitions: RUN -> MEM_WAIT on MemReq & !MemReady, WCnt<=1. MEM_WAIT: MemReady=1 -> RUN (that cycle is an advance cycle, evaluated by priority above); else if WCnt==MEM_TIMEOUT -> FAULT, MemError<=1; else WCnt<=WCnt+1. FAULT held until reset.
- Branch or load-use coincident with a freeze is not lost: the freeze holds EX/ID contents, so the condition re-evaluates on the release cycle.
- Outputs are combinational from state and inputs (Mealy); only state, WCnt, MemError, StallCycles are registered.

## Timing
- Reset asserted (async): state=RUN, WCnt=0, MemError=0, StallCycles=0; outputs forced PCEnable=IFIDDevEnable=IDEXDevEnable=EXMEMDevEnable=0, IDEXEnable=0, IFIDFlush=0. First edge after deassert operates in RUN.
- Load-use: exactly one bubble cycle; next cycle the load is in MEM and detection clears.
- Branch flush: one cycle, same cycle EXBranchTaken seen.
- Memory freeze: entered combinationally in the first cycle MemReq&!MemReady; released in the cycle MemReady=1. MemReady=1 in the first MemReq cycle: no freeze, no state change.
- Timeout: FAULT entered on the edge ending the cycle where WCnt==MEM_TIMEOUT and MemReady=0; MemError high from the following cycle.
- Reset mid-MEM_WAIT or in FAULT: immediate return to reset values.

## Configuration
- HAZARD_STALL_CNT_EN defined: StallCycles increments by 1 on each post-reset cycle with PCEnable=0, saturating at 16'hFFFF.
- Not defined: counter logic absent, StallCycles tied to 16'h0000.

## Test plan
- Load-use: EX lw with EXrt=5, EXMemToReg=EXRegWrite=1, IDrs=5 -> one cycle PCEnable=0, IFIDDevEnable=0, IDEXEnable=0, IDEXDevEnable=1; EXrt=0 -> no stall.
- Branch + load-use same cycle: EXBranchTaken=1 with load-use true -> IFIDFlush=1, IDEXEnable=0, PCEnable=1.
- Mem wait: MemReq=1, MemReady low 3 cycles then high -> 3 freeze cycles, release cycle all enables 1, state RUN; StallCycles=3 with HAZARD_STALL_CNT_EN.
- Timeout: MEM_TIMEOUT=4, MemReady held 0 -> MemError=1 after 4 wait cycles, freeze persists; MemReady later 1 -> no release.
- Reset mid-wait: ResetN low during MEM_WAIT -> all enables 0 asynchronously, MemError 0; after release, normal advance.
- Branch during freeze: EXBranchTaken=1 throughout a 2-cycle memory wait -> IFIDFlush asserted only in release cycle.
